// File: rtl/execute.sv
// rtl/execute.sv - EX stage: operand select, five-op ALU and EX/MEM pipeline register
module execute (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWr_ID,
  input  logic        MemWr_ID,
  input  logic        MemRd_ID,
  input  logic [1:0]  WBdata_ID,
  input  logic        ALUSrc_ID,
  input  logic [2:0]  ALUop_ID,
  input  logic [31:0] npc2,
  input  logic [31:0] imm,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  rd2,
  input  logic        RPzero_ID,
  output logic        RegWr_EX,
  output logic        MemWr_EX,
  output logic        MemRd_EX,
  output logic [1:0]  WBdata_EX,
  output logic [31:0] ALUout_EX,
  output logic [31:0] D,
  output logic [31:0] npc3,
  output logic [3:0]  rd3,
  output logic        RPzero_EX
);

  logic [31:0] op2;
  logic [31:0] alu_result;

  assign op2 = ALUSrc_ID ? imm : B;

  // Unused opcodes 101..111 yield zero.
  always_comb begin
    alu_result = 32'h0;
    case (ALUop_ID)
      3'b000:  alu_result = A + op2;
      3'b001:  alu_result = A - op2;
      3'b010:  alu_result = A | op2;
      3'b011:  alu_result = ~(A | op2);
      3'b100:  alu_result = A & op2;
      default: alu_result = 32'h0;
    endcase
  end

  // Killed instructions are carried through unsquashed; later stages gate on RPzero_EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWr_EX  <= 1'b0;
      MemWr_EX  <= 1'b0;
      MemRd_EX  <= 1'b0;
      WBdata_EX <= 2'b00;
      ALUout_EX <= 32'h0;
      D         <= 32'h0;
      npc3      <= 32'h0;
      rd3       <= 4'h0;
      RPzero_EX <= 1'b0;
    end else begin
      RegWr_EX  <= RegWr_ID;
      MemWr_EX  <= MemWr_ID;
      MemRd_EX  <= MemRd_ID;
      WBdata_EX <= WBdata_ID;
      ALUout_EX <= alu_result;
      D         <= B;
      npc3      <= npc2;
      rd3       <= rd2;
      RPzero_EX <= RPzero_ID;
    end
  end

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - scoreboard bench for the execute stage
module tb_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWr_ID, MemWr_ID, MemRd_ID, ALUSrc_ID, RPzero_ID;
  logic [1:0]  WBdata_ID;
  logic [2:0]  ALUop_ID;
  logic [31:0] npc2, imm, A, B;
  logic [3:0]  rd2;
  logic        RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX;
  logic [1:0]  WBdata_EX;
  logic [31:0] ALUout_EX, D, npc3;
  logic [3:0]  rd3;

  execute dut (
    .clk(clk), .reset(reset),
    .RegWr_ID(RegWr_ID), .MemWr_ID(MemWr_ID), .MemRd_ID(MemRd_ID),
    .WBdata_ID(WBdata_ID), .ALUSrc_ID(ALUSrc_ID), .ALUop_ID(ALUop_ID),
    .npc2(npc2), .imm(imm), .A(A), .B(B), .rd2(rd2), .RPzero_ID(RPzero_ID),
    .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX), .MemRd_EX(MemRd_EX),
    .WBdata_EX(WBdata_EX), .ALUout_EX(ALUout_EX), .D(D), .npc3(npc3),
    .rd3(rd3), .RPzero_EX(RPzero_EX)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] alu;
    logic [31:0] d;
    logic [31:0] npc;
    logic [3:0]  rd;
    logic [1:0]  wb;
    logic [3:0]  ctl;   // {RegWr, MemWr, MemRd, RPzero}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] vec_id = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one instruction on a falling edge; the expected EX/MEM contents are hand-computed.
  task automatic issue(input logic [2:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] npc,
                       input logic [3:0] rd, input logic [1:0] wb, input logic [3:0] ctl,
                       input logic [31:0] exp_alu);
    exp_t e;
    @(negedge clk);
    ALUop_ID  = op;  ALUSrc_ID = src;
    A = a;  B = b;  imm = im;  npc2 = npc;  rd2 = rd;  WBdata_ID = wb;
    {RegWr_ID, MemWr_ID, MemRd_ID, RPzero_ID} = ctl;
    vec_id = vec_id + 8'd1;
    e.id = vec_id;  e.alu = exp_alu;  e.d = b;  e.npc = npc;
    e.rd = rd;  e.wb = wb;  e.ctl = ctl;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge presents a result; compare it against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("v%0d alu", e.id),  ALUout_EX, e.alu);
      check($sformatf("v%0d d", e.id),    D, e.d);
      check($sformatf("v%0d npc3", e.id), npc3, e.npc);
      check($sformatf("v%0d rd3", e.id),  {28'h0, rd3}, {28'h0, e.rd});
      check($sformatf("v%0d wb", e.id),   {30'h0, WBdata_EX}, {30'h0, e.wb});
      check($sformatf("v%0d ctl", e.id),
            {28'h0, RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX}, {28'h0, e.ctl});
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {24'h0, RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX, WBdata_EX, 2'b00}, 32'h0);
    check({name, " alu"}, ALUout_EX, 32'h0);
    check({name, " d"}, D, 32'h0);
    check({name, " npc3"}, npc3, 32'h0);
    check({name, " rd3"}, {28'h0, rd3}, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain queue empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    RegWr_ID = 0; MemWr_ID = 0; MemRd_ID = 0; ALUSrc_ID = 0; RPzero_ID = 0;
    WBdata_ID = 2'b00; ALUop_ID = 3'b000;
    npc2 = 32'h0; imm = 32'h0; A = 32'h0; B = 32'h0; rd2 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset state");
    @(negedge clk);
    reset = 1'b1;

    //     op      src a             b      imm   npc        rd    wb     ctl      expected
    issue(3'b000, 0, 32'd10,       32'd5,  0,    32'h100,   4'd3, 2'b00, 4'b1000, 32'd15);
    issue(3'b001, 0, 32'd10,       32'd4,  0,    32'h104,   4'd4, 2'b01, 4'b1000, 32'd6);
    issue(3'b100, 0, 32'd8,        32'd3,  0,    32'h108,   4'd5, 2'b00, 4'b0000, 32'd0);
    issue(3'b010, 0, 32'd8,        32'd1,  0,    32'h10C,   4'd6, 2'b00, 4'b1000, 32'd9);
    issue(3'b011, 0, 32'd8,        32'd1,  0,    32'h110,   4'd7, 2'b00, 4'b1000, 32'hFFFFFFF6);
    issue(3'b000, 1, 32'd20,       32'd1,  32'd7, 32'h114,  4'd8, 2'b00, 4'b1000, 32'd27);
    issue(3'b000, 1, 32'd20,       32'd99, 32'd7, 32'h118,  4'd8, 2'b00, 4'b0100, 32'd27);
    issue(3'b000, 0, 32'd1,        32'd2,  0,    32'h11C,   4'd9, 2'b00, 4'b1001, 32'd3);
    issue(3'b001, 0, 32'd0,        32'd1,  0,    32'h120,   4'd1, 2'b00, 4'b1000, 32'hFFFFFFFF);
    issue(3'b000, 0, 32'hFFFFFFFF, 32'd1,  0,    32'h124,   4'd2, 2'b00, 4'b1000, 32'd0);
    issue(3'b111, 0, 32'd5,        32'd6,  0,    32'h128,   4'd3, 2'b00, 4'b1000, 32'd0);
    issue(3'b101, 0, 32'd5,        32'd6,  0,    32'h12C,   4'd3, 2'b00, 4'b1000, 32'd0);
    issue(3'b110, 1, 32'd5,        32'd6,  32'd9, 32'h130,  4'd3, 2'b00, 4'b1000, 32'd0);
    issue(3'b010, 0, 32'hF0F0_0000, 32'h0000_0F0F, 0, 32'h1234, 4'd15, 2'b10, 4'b0010, 32'hF0F0_0F0F);
    drain();

    // Inputs moving between edges must not reach the outputs.
    A = 32'h5555; B = 32'h7777; ALUop_ID = 3'b000; npc2 = 32'hDEAD;
    #1;
    check("hold alu between edges", ALUout_EX, 32'hF0F0_0F0F);
    check("hold npc3 between edges", npc3, 32'h1234);

    // Load everything non-zero, then assert reset mid-cycle.
    issue(3'b000, 0, 32'h10, 32'h20, 0, 32'hABCD, 4'hF, 2'b11, 4'b1111, 32'h30);
    drain();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async reset mid-cycle");
    @(posedge clk); #1;
    check_all_zero("reset held edge 1");
    @(posedge clk); #1;
    check_all_zero("reset held edge 2");

    @(negedge clk);
    reset = 1'b1;
    issue(3'b001, 0, 32'd100, 32'd1, 0, 32'h200, 4'd6, 2'b01, 4'b1010, 32'd99);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
